// File: rtl/tlu_trigger_scheduler.sv
// Trigger arbiter/sequencer: request edge detection, round-robin grant, prescale and
// FIFO-full veto, then a FIRE / DEAD / WAIT_READY sequence per issued trigger.
module tlu_trigger_scheduler #(
  parameter int N_SRC = 3,
  parameter int N_DUT = 6
) (
  input  logic             CLK40,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ENABLE,
  input  logic [N_SRC-1:0] SRC_EN,
  input  logic [N_SRC-1:0] TRIG_REQ,
  input  logic [15:0]      PRESCALE,
  input  logic [7:0]       DEAD_TIME,
  input  logic [N_DUT-1:0] DUT_EN,
  input  logic [N_DUT-1:0] DUT_READY,
  input  logic             FIFO_FULL,
  output logic             TRIG_OUT,
  output logic [1:0]       TRIG_SRC,
  output logic [31:0]      TRIG_ID,
  output logic [7:0]       SKIP_CNT,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_DEAD = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_SRC-1:0] r_req_d;
  logic [1:0]       r_rr_ptr;
  logic [15:0]      r_pre_cnt;
  logic [7:0]       r_dead_cnt;
  logic             r_trig_out;
  logic [1:0]       r_trig_src;
  logic [31:0]      r_trig_id;
  logic [7:0]       r_skip_cnt;
  logic             r_busy;

  logic [N_SRC-1:0] w_edge;
  logic             w_any_edge;
  logic [2:0]       w_edge_cnt;
  logic [1:0]       w_grant;
  logic [1:0]       w_idx;
  logic             w_found;
  logic [1:0]       w_rr_nxt;
  logic             w_grant_ev;
  logic             w_hit;
  logic             w_fire;
  logic             w_all_ready;
  logic [2:0]       w_rej_cnt;
  logic [8:0]       w_skip_sum;
  logic [7:0]       w_skip_nxt;

  assign w_edge      = TRIG_REQ & ~r_req_d & SRC_EN & {N_SRC{ENABLE}};
  assign w_any_edge  = |w_edge;
  assign w_edge_cnt  = 3'($countones(w_edge));
  assign w_all_ready = &(DUT_READY | ~DUT_EN);
  assign w_grant_ev  = (r_state == S_IDLE) && w_any_edge && !FIFO_FULL && !START;
  assign w_hit       = (PRESCALE <= 16'd1) || (r_pre_cnt == (PRESCALE - 16'd1));
  assign w_fire      = w_grant_ev && w_hit;
  assign w_rr_nxt    = ((int'(w_grant) + 1) >= N_SRC) ? 2'd0 : (w_grant + 2'd1);

  // Round-robin search: first pending edge at or after the pointer, wrapping.
  always_comb begin
    w_grant = 2'd0;
    w_found = 1'b0;
    w_idx   = 2'd0;
    for (int k = 0; k < N_SRC; k++) begin
      w_idx   = 2'((int'(r_rr_ptr) + k) % N_SRC);
      w_grant = (!w_found && w_edge[w_idx]) ? w_idx : w_grant;
      w_found = w_found | w_edge[w_idx];
    end
  end

  // Rejected-edge tally: busy/vetoed edges all count, otherwise only arbitration losers.
  always_comb begin
    w_rej_cnt = 3'd0;
    if (START) begin
      w_rej_cnt = 3'd0;
    end else if ((r_state != S_IDLE) || FIFO_FULL) begin
      w_rej_cnt = w_edge_cnt;
    end else if (w_any_edge) begin
      w_rej_cnt = w_edge_cnt - 3'd1;
    end else begin
      w_rej_cnt = 3'd0;
    end
    w_skip_sum = {1'b0, r_skip_cnt} + {6'd0, w_rej_cnt};
    w_skip_nxt = w_skip_sum[8] ? 8'hFF : w_skip_sum[7:0];
  end

  // Next-state logic for the trigger sequence; START forces IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (START) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = w_fire ? S_FIRE : S_IDLE;
        S_FIRE:  w_state_nxt = (DEAD_TIME != 8'd0) ? S_DEAD : S_WAIT;
        S_DEAD:  w_state_nxt = (r_dead_cnt <= 8'd1) ? S_WAIT : S_DEAD;
        S_WAIT:  w_state_nxt = w_all_ready ? S_IDLE : S_WAIT;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers: counters, arbitration pointer and registered outputs.
  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      r_req_d    <= '0;
      r_rr_ptr   <= 2'd0;
      r_pre_cnt  <= 16'd0;
      r_dead_cnt <= 8'd0;
      r_trig_out <= 1'b0;
      r_trig_src <= 2'd0;
      r_trig_id  <= 32'd0;
      r_skip_cnt <= 8'd0;
      r_busy     <= 1'b0;
    end else begin
      r_req_d <= TRIG_REQ;
      r_busy  <= (w_state_nxt != S_IDLE);
      if (START) begin
        r_rr_ptr   <= 2'd0;
        r_pre_cnt  <= 16'd0;
        r_dead_cnt <= 8'd0;
        r_trig_out <= 1'b0;
        r_trig_id  <= 32'd0;
        r_skip_cnt <= 8'd0;
      end else begin
        r_trig_out <= w_fire;
        r_skip_cnt <= w_skip_nxt;
        if (w_grant_ev) begin
          r_rr_ptr  <= w_rr_nxt;
          r_pre_cnt <= w_hit ? 16'd0 : (r_pre_cnt + 16'd1);
        end
        if (w_fire) begin
          r_trig_src <= w_grant;
          r_trig_id  <= r_trig_id + 32'd1;
        end
        // DEAD_TIME is captured on the way out of FIRE, i.e. on DEAD entry.
        if (r_state == S_FIRE) begin
          r_dead_cnt <= DEAD_TIME;
        end else if (r_state == S_DEAD) begin
          r_dead_cnt <= r_dead_cnt - 8'd1;
        end
      end
    end
  end

  assign TRIG_OUT = r_trig_out;
  assign TRIG_SRC = r_trig_src;
  assign TRIG_ID  = r_trig_id;
  assign SKIP_CNT = r_skip_cnt;
  assign BUSY     = r_busy;

endmodule

// File: tb/tb_tlu_trigger_scheduler.sv
// Directed bench for tlu_trigger_scheduler: a cycle model built from busy windows,
// round-robin search and grant counting is compared every cycle, plus literal checks.
module tb_tlu_trigger_scheduler;
  localparam int N_SRC = 3;
  localparam int N_DUT = 6;

  logic             CLK40;
  logic             RST_N;
  logic             START;
  logic             ENABLE;
  logic [N_SRC-1:0] SRC_EN;
  logic [N_SRC-1:0] TRIG_REQ;
  logic [15:0]      PRESCALE;
  logic [7:0]       DEAD_TIME;
  logic [N_DUT-1:0] DUT_EN;
  logic [N_DUT-1:0] DUT_READY;
  logic             FIFO_FULL;
  logic             TRIG_OUT;
  logic [1:0]       TRIG_SRC;
  logic [31:0]      TRIG_ID;
  logic [7:0]       SKIP_CNT;
  logic             BUSY;

  tlu_trigger_scheduler #(.N_SRC(N_SRC), .N_DUT(N_DUT)) dut (
    .CLK40(CLK40), .RST_N(RST_N), .START(START), .ENABLE(ENABLE), .SRC_EN(SRC_EN),
    .TRIG_REQ(TRIG_REQ), .PRESCALE(PRESCALE), .DEAD_TIME(DEAD_TIME), .DUT_EN(DUT_EN),
    .DUT_READY(DUT_READY), .FIFO_FULL(FIFO_FULL), .TRIG_OUT(TRIG_OUT),
    .TRIG_SRC(TRIG_SRC), .TRIG_ID(TRIG_ID), .SKIP_CNT(SKIP_CNT), .BUSY(BUSY)
  );

  initial CLK40 = 1'b0;
  always #10 CLK40 = ~CLK40;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;

  // Model state: expected outputs plus the bookkeeping needed to predict them.
  logic             m_trig;
  logic [1:0]       m_src;
  logic [31:0]      m_id;
  logic [7:0]       m_skip;
  logic             m_busy;
  logic [N_SRC-1:0] m_req_d;
  int               m_rr;
  int               m_gcount;
  int               m_cyc;
  int               m_fixed_end;

  task automatic model_reset();
    m_trig = 1'b0; m_src = 2'd0; m_id = 32'd0; m_skip = 8'd0; m_busy = 1'b0;
    m_req_d = '0; m_rr = 0; m_gcount = 0; m_fixed_end = -100;
  endtask

  // One clock of the model, using the inputs currently driven.
  task automatic model_step();
    logic [N_SRC-1:0] e;
    int ne, rej, g, sum;
    bit found, rdy, nxt_busy;
    e = TRIG_REQ & ~m_req_d & SRC_EN & {N_SRC{ENABLE}};
    m_req_d = TRIG_REQ;
    m_trig = 1'b0;
    if (START) begin
      m_id = 32'd0; m_skip = 8'd0; m_gcount = 0; m_rr = 0; m_busy = 1'b0;
      m_fixed_end = -100;
      m_cyc++;
      return;
    end
    ne = $countones(e);
    rdy = &(DUT_READY | ~DUT_EN);
    rej = 0;
    nxt_busy = 1'b0;
    if (m_busy) begin
      rej = ne;
      nxt_busy = (m_cyc + 1 <= m_fixed_end + 1) ? 1'b1 : !rdy;
    end else if (ne != 0 && FIFO_FULL) begin
      rej = ne;
    end else if (ne != 0) begin
      rej = ne - 1;
      found = 1'b0;
      g = 0;
      for (int k = 0; k < N_SRC; k++) begin
        int idx;
        idx = (m_rr + k) % N_SRC;
        if (!found && e[idx]) begin found = 1'b1; g = idx; end
      end
      m_rr = (g + 1) % N_SRC;
      m_gcount++;
      if (PRESCALE <= 16'd1 || (m_gcount % int'(PRESCALE)) == 0) begin
        m_trig = 1'b1;
        m_src = 2'(g);
        m_id = m_id + 32'd1;
        m_fixed_end = m_cyc + 1 + int'(DEAD_TIME);
        nxt_busy = 1'b1;
      end
    end
    sum = int'(m_skip) + rej;
    m_skip = 8'((sum > 255) ? 255 : sum);
    m_busy = nxt_busy;
    m_cyc++;
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic tick();
    model_step();
    @(posedge CLK40);
    #1;
    n_tests++;
    if (TRIG_OUT !== m_trig || TRIG_SRC !== m_src || TRIG_ID !== m_id ||
        SKIP_CNT !== m_skip || BUSY !== m_busy) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t: trig/src/id/skip/busy got %0b/%0d/%h/%0d/%0b want %0b/%0d/%h/%0d/%0b",
               $time, TRIG_OUT, TRIG_SRC, TRIG_ID, SKIP_CNT, BUSY,
               m_trig, m_src, m_id, m_skip, m_busy);
    end
    if (TRIG_OUT === 1'b1) pulse_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_start();
    START = 1'b1; tick(); START = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; START = 1'b0; ENABLE = 1'b1; SRC_EN = 3'b111; TRIG_REQ = 3'b000;
    PRESCALE = 16'd0; DEAD_TIME = 8'd4; DUT_EN = 6'h3F; DUT_READY = 6'h3F; FIFO_FULL = 1'b0;
    model_reset();
    m_cyc = 0;
    @(posedge CLK40); @(posedge CLK40); #1;
    chk("reset_trig", {31'd0, TRIG_OUT}, 32'd0);
    chk("reset_id", TRIG_ID, 32'd0);
    chk("reset_skip_busy_src", {22'd0, SKIP_CNT, BUSY, TRIG_SRC}, 32'd0);
    #5 RST_N = 1'b1;

    // Single request on source 1 at cycle 10.
    ticks(10);
    TRIG_REQ = 3'b010; tick(); TRIG_REQ = 3'b000;
    chk("single_trig_c11", {31'd0, TRIG_OUT}, 32'd1);
    chk("single_src", {30'd0, TRIG_SRC}, 32'd1);
    chk("single_id", TRIG_ID, 32'd1);
    ticks(5);
    chk("single_busy_c16", {31'd0, BUSY}, 32'd1);
    tick();
    chk("single_idle_c17", {31'd0, BUSY}, 32'd0);

    // Round-robin over simultaneous edges.
    do_start();
    for (int r = 0; r < 3; r++) begin
      TRIG_REQ = 3'b111; tick(); TRIG_REQ = 3'b000;
      chk("rr_src", {30'd0, TRIG_SRC}, 32'(r));
      ticks(8);
    end
    chk("rr_skip", {24'd0, SKIP_CNT}, 32'd6);
    chk("rr_id", TRIG_ID, 32'd3);

    // Prescale by 3.
    do_start();
    PRESCALE = 16'd3;
    pulse_cnt = 0;
    for (int r = 0; r < 9; r++) begin
      TRIG_REQ = 3'b001; tick(); TRIG_REQ = 3'b000; ticks(8);
    end
    chk("pre_pulses", 32'(pulse_cnt), 32'd3);
    chk("pre_id", TRIG_ID, 32'd3);
    chk("pre_skip", {24'd0, SKIP_CNT}, 32'd0);
    PRESCALE = 16'd0;

    // DUT busy holds the sequence; edges meanwhile are skipped.
    do_start();
    TRIG_REQ = 3'b001; tick(); TRIG_REQ = 3'b000; DUT_READY = 6'h2F;
    pulse_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      TRIG_REQ = (i == 10 || i == 20 || i == 30 || i == 40 || i == 45) ? 3'b010 : 3'b000;
      tick();
    end
    TRIG_REQ = 3'b000;
    chk("veto_no_trig", 32'(pulse_cnt), 32'd0);
    chk("veto_skip", {24'd0, SKIP_CNT}, 32'd5);
    chk("veto_busy", {31'd0, BUSY}, 32'd1);
    DUT_READY = 6'h3F; ticks(2);
    TRIG_REQ = 3'b001; tick(); TRIG_REQ = 3'b000;
    chk("release_fires", {31'd0, TRIG_OUT}, 32'd1);
    ticks(8);
    FIFO_FULL = 1'b1; pulse_cnt = 0;
    for (int r = 0; r < 2; r++) begin
      TRIG_REQ = 3'b001; tick(); TRIG_REQ = 3'b000; tick();
    end
    chk("fifo_skip", {24'd0, SKIP_CNT}, 32'd7);
    chk("fifo_no_trig", 32'(pulse_cnt), 32'd0);

    // Saturation of the skip counter, then trigger-number wrap.
    for (int r = 0; r < 300; r++) begin
      TRIG_REQ = 3'b100; tick(); TRIG_REQ = 3'b000; tick();
    end
    chk("skip_sat", {24'd0, SKIP_CNT}, 32'h0000_00FF);
    FIFO_FULL = 1'b0; tick();
    force dut.r_trig_id = 32'hFFFF_FFFF;
    release dut.r_trig_id;
    m_id = 32'hFFFF_FFFF;
    TRIG_REQ = 3'b100; tick(); TRIG_REQ = 3'b000;
    chk("id_wrap", TRIG_ID, 32'd0);
    chk("id_wrap_trig", {31'd0, TRIG_OUT}, 32'd1);
    ticks(8);

    // START during a long DEAD period.
    DEAD_TIME = 8'd200;
    do_start();
    TRIG_REQ = 3'b001; tick(); ticks(5);
    START = 1'b1; tick(); START = 1'b0;
    chk("start_idle", {31'd0, BUSY}, 32'd0);
    chk("start_id", TRIG_ID, 32'd0);
    chk("start_skip", {24'd0, SKIP_CNT}, 32'd0);
    TRIG_REQ = 3'b011; tick();
    chk("start_refire", {31'd0, TRIG_OUT}, 32'd1);
    chk("start_refire_src", {30'd0, TRIG_SRC}, 32'd1);
    chk("start_refire_id", TRIG_ID, 32'd1);

    // Asynchronous reset during FIRE drops outputs without a clock edge.
    #3 RST_N = 1'b0;
    #1;
    chk("async_rst_trig", {31'd0, TRIG_OUT}, 32'd0);
    chk("async_rst_busy_id", {TRIG_ID[30:0], BUSY}, 32'd0);
    model_reset();
    TRIG_REQ = 3'b000; DEAD_TIME = 8'd0;
    #5 RST_N = 1'b1;

    // Zero dead time: triggers three cycles apart; ENABLE low blocks edges.
    ticks(2);
    pulse_cnt = 0;
    for (int r = 0; r < 2; r++) begin
      TRIG_REQ = 3'b001; tick(); TRIG_REQ = 3'b000; ticks(2);
    end
    chk("dt0_pulses", 32'(pulse_cnt), 32'd2);
    ENABLE = 1'b0;
    TRIG_REQ = 3'b010; tick(); TRIG_REQ = 3'b000; ticks(3);
    chk("disabled_pulses", 32'(pulse_cnt), 32'd2);
    chk("disabled_skip", {24'd0, SKIP_CNT}, 32'd0);
    ENABLE = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
